// File: rtl/cannon_sequencer.sv
// Control FSM sequencing a SQRT_P x SQRT_P Cannon block-multiply grid through one C = A x B job.
// Optional cycle counter behind macro CANNON_SEQ_PERF_EN; otherwise perf_cycles is tied to 0.
module cannon_sequencer #(
  parameter int SQRT_P  = 2,
  parameter int MAC_LAT = 2,
  parameter int STEP_W  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic              out_ack,
  output logic              busy,
  output logic              load_en,
  output logic              clear_acc,
  output logic              skew_en,
  output logic              mac_en,
  output logic              acc_we,
  output logic              shift_en,
  output logic [STEP_W-1:0] step_idx,
  output logic              out_valid,
  output logic              done,
  output logic [31:0]       perf_cycles
);

  localparam int LAT_W = (MAC_LAT > 1) ? $clog2(MAC_LAT) : 1;
  localparam logic [LAT_W-1:0]  LAST_LAT  = LAT_W'(MAC_LAT - 1);
  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(SQRT_P - 1);
  localparam logic [STEP_W-1:0] LAST_SKEW = (SQRT_P > 1) ? STEP_W'(SQRT_P - 2) : '0;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_CLEAR, S_SKEW, S_MAC, S_SHIFT, S_OUT
  } state_e;

  state_e            state_q, state_d;
  logic [STEP_W-1:0] step_q, step_d;
  logic [LAT_W-1:0]  lat_q, lat_d;
  logic              done_q, done_d;

  // State and counter registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      step_q  <= '0;
      lat_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      lat_q   <= lat_d;
      done_q  <= done_d;
    end
  end

  // Next-state logic; abort overrides every busy state
  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    lat_d   = lat_q;
    done_d  = 1'b0;
    if (abort && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      step_d  = '0;
      lat_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start && !abort) state_d = S_LOAD;
          else                 state_d = S_IDLE;
        end
        S_LOAD:  state_d = S_CLEAR;
        S_CLEAR: begin
          step_d  = '0;
          state_d = (SQRT_P > 1) ? S_SKEW : S_MAC;
        end
        S_SKEW: begin
          if (step_q == LAST_SKEW) begin
            state_d = S_MAC;
            step_d  = '0;
          end else begin
            step_d  = step_q + STEP_W'(1);
          end
        end
        S_MAC: begin
          if (lat_q == LAST_LAT) begin
            lat_d = '0;
            if (step_q == LAST_STEP) begin
              state_d = S_OUT;
              step_d  = '0;
            end else begin
              state_d = S_SHIFT;
            end
          end else begin
            lat_d = lat_q + LAT_W'(1);
          end
        end
        S_SHIFT: begin
          state_d = S_MAC;
          step_d  = step_q + STEP_W'(1);
        end
        S_OUT: begin
          if (out_ack) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = S_OUT;
          end
        end
        default: begin
          state_d = S_IDLE;
          step_d  = '0;
          lat_d   = '0;
        end
      endcase
    end
  end

  // Output decode from registered state only
  always_comb begin
    busy      = (state_q != S_IDLE);
    load_en   = (state_q == S_LOAD);
    clear_acc = (state_q == S_CLEAR);
    skew_en   = (state_q == S_SKEW);
    mac_en    = (state_q == S_MAC);
    acc_we    = (state_q == S_MAC) && (lat_q == LAST_LAT);
    shift_en  = (state_q == S_SHIFT);
    out_valid = (state_q == S_OUT);
    done      = done_q;
    if ((state_q == S_SKEW) || (state_q == S_MAC) || (state_q == S_SHIFT)) step_idx = step_q;
    else                                                                     step_idx = '0;
  end

`ifdef CANNON_SEQ_PERF_EN
  logic [31:0] cnt_q;
  logic [31:0] perf_q;
  logic [31:0] cnt_inc_s;

  assign cnt_inc_s = (cnt_q == 32'hFFFF_FFFF) ? cnt_q : cnt_q + 32'd1;

  // Busy-cycle counter; snapshot taken on the cycle that leads into done
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q  <= 32'd0;
      perf_q <= 32'd0;
    end else begin
      if (state_q == S_IDLE) begin
        if (start && !abort) cnt_q <= 32'd0;
        else                 cnt_q <= cnt_q;
      end else begin
        cnt_q <= cnt_inc_s;
      end
      if (done_d) perf_q <= cnt_inc_s;
      else        perf_q <= perf_q;
    end
  end

  assign perf_cycles = perf_q;
`else
  assign perf_cycles = 32'd0;
`endif

endmodule

// File: tb/tb_cannon_sequencer.sv
// Bench for cannon_sequencer: two instances (2x2 grid / MAC_LAT 2, and 1x1 grid / MAC_LAT 3)
// checked cycle by cycle against an expected strobe schedule built from the job phase rules.
module tb_cannon_sequencer;

  localparam int K_IDLE = 0, K_LOAD = 1, K_CLEAR = 2, K_SKEW = 3, K_MAC = 4,
                 K_SHIFT = 5, K_OUT = 6, K_DONE = 7;

  logic       clk;
  logic       reset;
  logic [1:0] start_s, abort_s, ack_s;
  logic [1:0] busy_s, load_s, clr_s, skew_s, mac_s, accwe_s, shift_s, ov_s, done_s;
  logic [3:0] step_s [2];
  logic [31:0] perf_s [2];

  int n_cmp = 0;
  int n_err = 0;
  int exp_perf [2];
  logic [12:0] exp_q [$];
  int n_pre;

  cannon_sequencer #(.SQRT_P(2), .MAC_LAT(2), .STEP_W(4)) dut (
    .clk(clk), .reset(reset), .start(start_s[0]), .abort(abort_s[0]), .out_ack(ack_s[0]),
    .busy(busy_s[0]), .load_en(load_s[0]), .clear_acc(clr_s[0]), .skew_en(skew_s[0]),
    .mac_en(mac_s[0]), .acc_we(accwe_s[0]), .shift_en(shift_s[0]), .step_idx(step_s[0]),
    .out_valid(ov_s[0]), .done(done_s[0]), .perf_cycles(perf_s[0])
  );

  cannon_sequencer #(.SQRT_P(1), .MAC_LAT(3), .STEP_W(4)) dut1 (
    .clk(clk), .reset(reset), .start(start_s[1]), .abort(abort_s[1]), .out_ack(ack_s[1]),
    .busy(busy_s[1]), .load_en(load_s[1]), .clear_acc(clr_s[1]), .skew_en(skew_s[1]),
    .mac_en(mac_s[1]), .acc_we(accwe_s[1]), .shift_en(shift_s[1]), .step_idx(step_s[1]),
    .out_valid(ov_s[1]), .done(done_s[1]), .perf_cycles(perf_s[1])
  );

  always #5 clk = ~clk;

  function automatic int p_of(input int u);
    return (u == 0) ? 2 : 1;
  endfunction

  function automatic int l_of(input int u);
    return (u == 0) ? 2 : 3;
  endfunction

  function automatic logic [12:0] obs(input int u);
    return {busy_s[u], load_s[u], clr_s[u], skew_s[u], mac_s[u], accwe_s[u],
            shift_s[u], ov_s[u], done_s[u], step_s[u]};
  endfunction

  function automatic logic [12:0] mk(input int k, input int idx, input bit aw);
    logic [12:0] v;
    v = 13'd0;
    v[12]  = (k >= K_LOAD) && (k <= K_OUT);
    v[11]  = (k == K_LOAD);
    v[10]  = (k == K_CLEAR);
    v[9]   = (k == K_SKEW);
    v[8]   = (k == K_MAC);
    v[7]   = aw;
    v[6]   = (k == K_SHIFT);
    v[5]   = (k == K_OUT);
    v[4]   = (k == K_DONE);
    v[3:0] = idx[3:0];
    return v;
  endfunction

  function automatic logic [31:0] perf_exp(input int u);
`ifdef CANNON_SEQ_PERF_EN
    return 32'(exp_perf[u]);
`else
    return 32'd0 + 32'(u - u);
`endif
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    n_cmp++;
    assert (o === e) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  // Whole-job schedule: load, clear, skew passes, MAC/shift steps, then out_valid cycles
  task automatic build(input int p, input int l, input int ack_delay);
    exp_q.delete();
    exp_q.push_back(mk(K_LOAD, 0, 1'b0));
    exp_q.push_back(mk(K_CLEAR, 0, 1'b0));
    for (int s = 0; s < p - 1; s++) exp_q.push_back(mk(K_SKEW, s, 1'b0));
    for (int s = 0; s < p; s++) begin
      for (int m = 0; m < l; m++) exp_q.push_back(mk(K_MAC, s, m == l - 1));
      if (s < p - 1) exp_q.push_back(mk(K_SHIFT, s, 1'b0));
    end
    n_pre = exp_q.size();
    for (int k = 0; k <= ack_delay; k++) exp_q.push_back(mk(K_OUT, 0, 1'b0));
  endtask

  task automatic run_job(input int u, input int ack_delay, input int abort_at);
    build(p_of(u), l_of(u), ack_delay);
    start_s[u] = 1'b1;
    abort_s[u] = 1'b0;
    ack_s[u]   = 1'b0;
    step();
    for (int i = 0; i < exp_q.size(); i++) begin
      chk("sched", 32'(obs(u)), 32'(exp_q[i]));
      if (i == abort_at) begin
        abort_s[u] = 1'b1;
        start_s[u] = 1'($urandom_range(0, 1));
        ack_s[u]   = 1'b0;
        step();
        abort_s[u] = 1'b0;
        start_s[u] = 1'b0;
        chk("abort_idle", 32'(obs(u)), 32'(mk(K_IDLE, 0, 1'b0)));
        chk("abort_perf", perf_s[u], perf_exp(u));
        return;
      end
      start_s[u] = 1'($urandom_range(0, 1));
      if (i < n_pre) ack_s[u] = 1'($urandom_range(0, 1));
      else           ack_s[u] = (i == exp_q.size() - 1);
      step();
    end
    start_s[u] = 1'b0;
    ack_s[u]   = 1'b0;
    exp_perf[u] = exp_q.size();
    chk("done", 32'(obs(u)), 32'(mk(K_DONE, 0, 1'b0)));
    chk("perf", perf_s[u], perf_exp(u));
  endtask

  initial begin
    int u, ad, ab, len, gap;
    clk = 1'b0;
    reset = 1'b1;
    start_s = 2'b00;
    abort_s = 2'b00;
    ack_s = 2'b00;
    exp_perf[0] = 0;
    exp_perf[1] = 0;
    #2;
    chk("reset0", 32'(obs(0)), 32'd0);
    chk("reset1", 32'(obs(1)), 32'd0);
    step();
    reset = 1'b0;
    step();
    chk("idle0", 32'(obs(0)), 32'(mk(K_IDLE, 0, 1'b0)));
    chk("perf_rst", perf_s[0], 32'd0);

    // Default grid, ack held off 3 cycles, then a back-to-back job from the done cycle
    run_job(0, 3, -1);
    run_job(0, 2, -1);
`ifdef CANNON_SEQ_PERF_EN
    chk("perf_11", perf_s[0], 32'd11);
`else
    chk("perf_0", perf_s[0], 32'd0);
`endif
    step();
    chk("done_1cyc", 32'(obs(0)), 32'(mk(K_IDLE, 0, 1'b0)));

    // Single-block grid: no skew or shift, out_valid after 5 cycles
    run_job(1, 1, -1);
    step();
    chk("idle1", 32'(obs(1)), 32'(mk(K_IDLE, 0, 1'b0)));

    // Abort on the first cycle of the step-1 MAC phase, then a clean job
    run_job(0, 1, 6);
    for (int k = 0; k < 3; k++) begin
      step();
      chk("no_done", 32'(obs(0)), 32'(mk(K_IDLE, 0, 1'b0)));
    end
    run_job(0, 0, -1);
    step();

    // Start together with abort in IDLE: abort wins
    start_s[0] = 1'b1;
    abort_s[0] = 1'b1;
    step();
    start_s[0] = 1'b0;
    abort_s[0] = 1'b0;
    chk("start_abort", 32'(obs(0)), 32'(mk(K_IDLE, 0, 1'b0)));

    // Stray ack in IDLE is ignored
    ack_s[0] = 1'b1;
    step();
    ack_s[0] = 1'b0;
    chk("stray_ack", 32'(obs(0)), 32'(mk(K_IDLE, 0, 1'b0)));

    // Async reset landing between edges while in SHIFT
    build(2, 2, 0);
    start_s[0] = 1'b1;
    step();
    start_s[0] = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("pre_rst", 32'(obs(0)), 32'(exp_q[i]));
      step();
    end
    chk("in_shift", 32'(obs(0)), 32'(mk(K_SHIFT, 0, 1'b0)));
    #2;
    reset = 1'b1;
    #1;
    chk("async_rst", 32'(obs(0)), 32'd0);
    chk("async_perf", perf_s[0], 32'd0);
    exp_perf[0] = 0;
    exp_perf[1] = 0;
    #2;
    reset = 1'b0;
    step();
    chk("post_rst", 32'(obs(0)), 32'(mk(K_IDLE, 0, 1'b0)));
    run_job(0, 0, -1);

    // Random jobs across both instances with random ack delays, aborts and idle gaps
    for (int j = 0; j < 24; j++) begin
      u   = $urandom_range(0, 1);
      ad  = $urandom_range(0, 3);
      len = 2 * (p_of(u) - 1) + p_of(u) * l_of(u) + 2 + ad + 1;
      ab  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, len - 1) : -1;
      run_job(u, ad, ab);
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) begin
        start_s[u] = 1'b0;
        abort_s[u] = 1'($urandom_range(0, 1));
        step();
        abort_s[u] = 1'b0;
        chk("gap_idle", 32'(obs(u)), 32'(mk(K_IDLE, 0, 1'b0)));
      end
    end
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
